tros_readout_serializer: RTL and testbench
==========================================

Name: tros_readout_serializer

Overview:
Parametrised successor to the single-channel counter readout. Captures one of N_CH latched ring-oscillator cycle counts and transmits it as a framed, registered Manchester stream (preamble, channel ID, data, optional parity). Adds a busy/done handshake and an auto-scan mode that sends every channel back to back. It sits between the per-oscillator frequency-measurement counters and the single uo_out data pin read by the RP2040.

Parameters:
N_CH, 4, number of counter channels (>=1)
CNT_W, 20, width of each channel count
PRE_W, 4, preamble length in bits
PREAMBLE, 4'b1010, preamble pattern, sent MSB first
SYNC_STAGES, 2, synchroniser depth for send_req (>=2)
GAP_BITS, 2, idle bit-times between frames in scan mode (>=1)
CH_W (localparam), max(1, clog2(N_CH)), channel-ID field width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; low freezes all state
send_req  in  1  asynchronous send request; rising edge starts a transfer
scan_mode  in  1  0 = single channel, 1 = all channels; sampled at start
ch_sel  in  CH_W  channel for single mode; sampled at start
cnt_bus  in  N_CH*CNT_W  latched counts; channel i at [i*CNT_W +: CNT_W]
tx_data  out  1  Manchester line, registered
tx_valid  out  1  high while frame bits are on the line
busy  out  1  transfer in progress
frame_done  out  1  one-cycle pulse after the last half-bit of each frame
scan_done  out  1  one-cycle pulse after the last frame of a transfer

Behaviour:
- Reset: asynchronous, active-low. All outputs are 0, FSM is IDLE, synchroniser is cleared.
- send_req passes through SYNC_STAGES flops, then a rising-edge detector. Only a 0->1 transition starts a transfer; a held level never restarts one.
- FSM states: IDLE, LOAD, SEND, GAP.
- IDLE -> LOAD on a detected edge. scan_mode and ch_sel are captured; channel index = ch_sel (single mode) or 0 (scan mode).
- LOAD (1 cycle):
  - Builds the frame {PREAMBLE, ch_id, data[, parity]} into the shift register.
  - busy is set.
  - If the index is >= N_CH, data is all zeros and ch_id is still the requested value.
  - The snapshot is frozen; later cnt_bus changes do not affect the frame.
- SEND: each bit occupies 2 clk cycles, MSB first.
  - Half 0: tx_data = bit. Half 1: tx_data = ~bit (1 = high-low, 0 = low-high).
  - tx_valid stays 1 for exactly 2*F cycles, where F = PRE_W + CH_W + CNT_W (+1 with parity).
- End of frame:
  - frame_done pulses.
  - Single mode, or last scan channel: scan_done pulses in the same cycle and the FSM returns to IDLE with busy = 0.
  - Otherwise go to GAP.
- GAP: tx_data = 0 and tx_valid = 0 for 2*GAP_BITS cycles, then increment the index and go to LOAD.
- Latency: tx_valid rises exactly SYNC_STAGES+2 clk edges after the first edge that samples send_req high.
- Edges detected while busy = 1 are discarded, not queued.
- ena = 0: FSM, shift register, counters and synchroniser hold; outputs hold their last values.
- Reset mid-frame: the line drops to 0 immediately with no partial-frame completion.
- Idle line: tx_data = 0, tx_valid = 0.

Optional Feature:
Macro TROS_READOUT_PARITY_EN.
- Defined: one even-parity bit is appended after the data. It is the XOR over the ch_id and data fields, so F grows by 1.
- Undefined: no parity bit and no parity logic.

Decomposition:
- Package tros_readout_pkg holds:
  - the FSM state enum;
  - the Manchester half-bit phase constant;
  - the default preamble;
  - a function computing CH_W from N_CH.
- One sub-module, tros_sync_edge: a parametrised SYNC_STAGES synchroniser plus rising-edge pulse generator with async active-low reset. It is reusable for latch_counter and ctr_reset.

Test Plan:
- Single frame: N_CH=4, CNT_W=20, ch1 = 0xABCDE, ch_sel=1, send_req pulse.
  -> after 4 edges, tx_valid high for 52 cycles.
  -> decoded bits 1010_01_1010_1011_1100_1101_1110.
  -> frame_done and scan_done pulse together; busy falls.
- Scan: counts 0x00001, 0x80000, 0xFFFFF, 0x12345, scan_mode=1.
  -> four frames with ch_id 00..11, each separated by 4 idle cycles.
  -> 4 frame_done pulses; 1 scan_done after the 4th.
- Snapshot and request handling:
  -> change cnt_bus and pulse send_req mid-frame: transmitted data is unchanged and no second transfer follows.
  -> hold send_req high for 200 cycles: exactly one transfer.
- Out-of-range channel: N_CH=3, ch_sel=3 -> frame ch_id = 11, data = 0x00000.
- Enable and reset:
  -> drop ena for 10 cycles mid-frame: line frozen, frame resumes and completes with correct bits.
  -> assert rst_n=0 mid-frame: tx_data, tx_valid and busy go to 0 before the next clk edge.
- TROS_READOUT_PARITY_EN defined:
  -> ch1 = 0xABCDE gives parity 0 and tx_valid for 54 cycles.
  -> ch1 = 0xABCDF gives parity 1.

Source files
------------

// File: rtl/tros_readout_pkg.sv
// Shared types and helpers for the ring-oscillator readout serializer.
package tros_readout_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Manchester half-bit phase: first half carries the bit, second half its inverse
  localparam logic PHASE_DATA = 1'b0;
  localparam logic PHASE_INV  = 1'b1;

  localparam logic [3:0] DEFAULT_PREAMBLE = 4'b1010;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tros_sync_edge.sv
// Multi-stage synchroniser followed by a rising-edge pulse detector.
module tros_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic rise_c
);

  // sh[STAGES-1] is the synchronised level, sh[STAGES] its previous value
  logic [STAGES:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= '0;
    end else if (en) begin
      sh <= {sh[STAGES-1:0], d};
    end
  end

  assign rise_c = sh[STAGES-1] & ~sh[STAGES];

endmodule

// File: rtl/tros_readout_serializer.sv
// Framed Manchester serializer for N_CH latched oscillator counts, single or scan mode.
// Define TROS_READOUT_PARITY_EN to append an even-parity bit over ch_id and data.
module tros_readout_serializer
  import tros_readout_pkg::*;
#(
  parameter int unsigned       N_CH        = 4,
  parameter int unsigned       CNT_W       = 20,
  parameter int unsigned       PRE_W       = 4,
  parameter logic [PRE_W-1:0]  PREAMBLE    = PRE_W'(DEFAULT_PREAMBLE),
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       GAP_BITS    = 2,
  localparam int unsigned      CH_W        = ch_width(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  send_req,
  input  logic                  scan_mode,
  input  logic [CH_W-1:0]       ch_sel,
  input  logic [N_CH*CNT_W-1:0] cnt_bus,
  output logic                  tx_data,
  output logic                  tx_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  scan_done
);

`ifdef TROS_READOUT_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned F        = PRE_W + CH_W + CNT_W + PAR_W;
  localparam int unsigned BIT_W    = $clog2(F);
  localparam int unsigned GAP_W    = $clog2(2 * GAP_BITS);
  // GAP plus the LOAD cycle together keep the line idle for 2*GAP_BITS cycles
  localparam int unsigned GAP_LAST = 2 * GAP_BITS - 2;

  state_t            state, state_nxt;
  logic [F-1:0]      shreg, shreg_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic              half, half_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic [CH_W-1:0]   idx, idx_nxt;
  logic              scan_r, scan_nxt;
  logic              tx_data_nxt, tx_valid_nxt, busy_nxt;
  logic              frame_done_nxt, scan_done_nxt;
  logic              rise_c;
  logic [CNT_W-1:0]  data_c;
  logic [F-1:0]      frame_c;

  tros_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (ena),
    .d      (send_req),
    .rise_c (rise_c)
  );

  // Channel select; an index beyond N_CH yields an all-zero count
  always_comb begin
    data_c = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (idx == CH_W'(i)) data_c = cnt_bus[i*CNT_W +: CNT_W];
    end
`ifdef TROS_READOUT_PARITY_EN
    frame_c = {PREAMBLE, idx, data_c, ^{idx, data_c}};
`else
    frame_c = {PREAMBLE, idx, data_c};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      half       <= PHASE_DATA;
      gap_cnt    <= '0;
      idx        <= '0;
      scan_r     <= 1'b0;
      tx_data    <= 1'b0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      scan_done  <= 1'b0;
    end else if (ena) begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      half       <= half_nxt;
      gap_cnt    <= gap_cnt_nxt;
      idx        <= idx_nxt;
      scan_r     <= scan_nxt;
      tx_data    <= tx_data_nxt;
      tx_valid   <= tx_valid_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
      scan_done  <= scan_done_nxt;
    end
  end

  // Output registers hold the half-bit shown during the cycle after the edge
  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    bit_cnt_nxt    = bit_cnt;
    half_nxt       = half;
    gap_cnt_nxt    = gap_cnt;
    idx_nxt        = idx;
    scan_nxt       = scan_r;
    tx_data_nxt    = 1'b0;
    tx_valid_nxt   = 1'b0;
    busy_nxt       = busy;
    frame_done_nxt = 1'b0;
    scan_done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (rise_c) begin
          state_nxt = LOAD;
          scan_nxt  = scan_mode;
          idx_nxt   = scan_mode ? '0 : ch_sel;
          busy_nxt  = 1'b1;
        end
      end
      LOAD: begin
        shreg_nxt    = frame_c;
        bit_cnt_nxt  = '0;
        half_nxt     = PHASE_DATA;
        tx_data_nxt  = frame_c[F-1];
        tx_valid_nxt = 1'b1;
        state_nxt    = SEND;
      end
      SEND: begin
        tx_valid_nxt = 1'b1;
        if (half == PHASE_DATA) begin
          half_nxt    = PHASE_INV;
          tx_data_nxt = ~shreg[F-1];
        end else if (bit_cnt == BIT_W'(F - 1)) begin
          tx_valid_nxt   = 1'b0;
          frame_done_nxt = 1'b1;
          if (!scan_r || (idx == CH_W'(N_CH - 1))) begin
            scan_done_nxt = 1'b1;
            busy_nxt      = 1'b0;
            state_nxt     = IDLE;
          end else begin
            gap_cnt_nxt = '0;
            state_nxt   = GAP;
          end
        end else begin
          shreg_nxt   = {shreg[F-2:0], 1'b0};
          bit_cnt_nxt = bit_cnt + BIT_W'(1);
          half_nxt    = PHASE_DATA;
          tx_data_nxt = shreg[F-2];
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_LAST)) begin
          idx_nxt   = idx + CH_W'(1);
          state_nxt = LOAD;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tros_readout_serializer.sv
// Randomised self-checking bench for tros_readout_serializer against a frame-level model.
module tb_tros_readout_serializer;

`ifdef TROS_READOUT_PARITY_EN
  localparam int F_EXP = 27;
`else
  localparam int F_EXP = 26;
`endif
  localparam int LAT      = 4;
  localparam int GAP_IDLE = 4;

  logic        clk = 1'b0;
  logic        rst_n, ena, send_req, scan_mode;
  logic [1:0]  ch_sel;
  logic [79:0] cnt_bus;
  logic        tx_data, tx_valid, busy, frame_done, scan_done;
  logic        tx_data3, tx_valid3, busy3, frame_done3, scan_done3;
  logic        use3;
  logic        m_data, m_valid, m_busy, m_fd, m_sd;
  logic        ena_seen = 1'b1;
  logic        v_prev = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          vrise_cnt = 0;
  int          fd_cnt = 0;
  int          sd_cnt = 0;
  logic [19:0] cnt_m [4];

  always #5 clk = ~clk;

  tros_readout_serializer u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .send_req   (send_req),
    .scan_mode  (scan_mode),
    .ch_sel     (ch_sel),
    .cnt_bus    (cnt_bus),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .busy       (busy),
    .frame_done (frame_done),
    .scan_done  (scan_done)
  );

  tros_readout_serializer #(.N_CH(3)) u_dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .send_req   (send_req),
    .scan_mode  (scan_mode),
    .ch_sel     (ch_sel),
    .cnt_bus    (cnt_bus[59:0]),
    .tx_data    (tx_data3),
    .tx_valid   (tx_valid3),
    .busy       (busy3),
    .frame_done (frame_done3),
    .scan_done  (scan_done3)
  );

  assign m_data  = use3 ? tx_data3    : tx_data;
  assign m_valid = use3 ? tx_valid3   : tx_valid;
  assign m_busy  = use3 ? busy3       : busy;
  assign m_fd    = use3 ? frame_done3 : frame_done;
  assign m_sd    = use3 ? scan_done3  : scan_done;

  always @(posedge clk) ena_seen <= ena;

  always @(negedge clk) begin
    if (tx_valid && !v_prev) vrise_cnt++;
    v_prev = tx_valid;
    if (ena_seen && frame_done) fd_cnt++;
    if (ena_seen && scan_done) sd_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: preamble, 2-bit channel id, 20-bit count, optional even parity
  function automatic logic [63:0] exp_frame(input int ch, input logic [19:0] d);
    logic [3:0]  pre = 4'b1010;
    logic [1:0]  id  = 2'(ch);
    logic [63:0] b;
    b = 64'({pre, id, d});
`ifdef TROS_READOUT_PARITY_EN
    b = {b[62:0], 1'(($countones(id) + $countones(d)) % 2)};
`endif
    return b;
  endfunction

  task automatic set_cnt(input int ch, input logic [19:0] v);
    cnt_m[ch] = v;
    cnt_bus[ch*20 +: 20] = v;
  endtask

  // Called just after a negedge; returns clk edges until tx_valid is seen high
  task automatic start_req(output int lat);
    lat = -1;
    send_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (m_valid) begin
        lat = n;
        break;
      end
    end
    send_req = 1'b0;
  endtask

  // Records half-bits while tx_valid is high; held cycles (ena low) must not move the line
  task automatic capture(output logic [63:0] bits, output int nhalf, output int bad,
                         output logic fd, output logic sd, output logic bz);
    logic q[$];
    logic last;
    int   guard;
    bad = 0; guard = 0; bits = '0; last = 1'b0;
    while (m_valid && guard < 400) begin
      if (ena_seen) begin
        q.push_back(m_data);
        last = m_data;
      end else if (m_data !== last) begin
        bad++;
      end
      guard++;
      @(negedge clk);
    end
    nhalf = q.size();
    for (int k = 0; k + 1 < nhalf; k += 2) begin
      bits = {bits[62:0], q[k]};
      if (q[k+1] !== ~q[k]) bad++;
    end
    fd = m_fd; sd = m_sd; bz = m_busy;
  endtask

  task automatic run_single(input int ch, input logic [19:0] d, input string tag, input int mode);
    int          lat, nh, bad;
    logic [63:0] got;
    logic        fd, sd, bz;
    scan_mode = 1'b0;
    ch_sel    = 2'(ch);
    start_req(lat);
    check({tag, "_lat"}, 64'(lat), 64'(LAT));
    case (mode)
      1: fork
        capture(got, nh, bad, fd, sd, bz);
        begin
          repeat (8) @(negedge clk);
          ena = 1'b0;
          repeat (10) @(negedge clk);
          ena = 1'b1;
        end
      join
      2: fork
        capture(got, nh, bad, fd, sd, bz);
        begin
          repeat (12) @(negedge clk);
          set_cnt(ch, ~d);
          send_req = 1'b1;
          repeat (3) @(negedge clk);
          send_req = 1'b0;
        end
      join
      default: capture(got, nh, bad, fd, sd, bz);
    endcase
    check({tag, "_bits"}, got, exp_frame(ch, d));
    check({tag, "_len"}, 64'(nh), 64'(2 * F_EXP));
    check({tag, "_manch"}, 64'(bad), 64'd0);
    check({tag, "_done"}, {62'd0, fd, sd}, 64'd3);
    check({tag, "_busy"}, 64'(bz), 64'd0);
    repeat (5) @(negedge clk);
  endtask

  task automatic run_scan();
    int          lat, nh, bad, idle, fd0, sd0;
    logic [63:0] got;
    logic        fd, sd, bz;
    fd0 = fd_cnt; sd0 = sd_cnt;
    scan_mode = 1'b1;
    ch_sel    = 2'($urandom_range(0, 3));
    start_req(lat);
    check("scan_lat", 64'(lat), 64'(LAT));
    for (int f = 0; f < 4; f++) begin
      capture(got, nh, bad, fd, sd, bz);
      check("scan_bits", got, exp_frame(f, cnt_m[f]));
      check("scan_len", 64'(nh), 64'(2 * F_EXP));
      check("scan_manch", 64'(bad), 64'd0);
      check("scan_done", {62'd0, fd, sd}, {62'd0, 1'b1, (f == 3)});
      check("scan_busy", 64'(bz), 64'(f != 3));
      if (f < 3) begin
        idle = 0;
        while (!m_valid && idle < 50) begin
          idle++;
          @(negedge clk);
        end
        check("scan_gap", 64'(idle), 64'(GAP_IDLE));
      end
    end
    repeat (5) @(negedge clk);
    check("scan_fd_cnt", 64'(fd_cnt - fd0), 64'd4);
    check("scan_sd_cnt", 64'(sd_cnt - sd0), 64'd1);
    scan_mode = 1'b0;
  endtask

  initial begin
    int          base, lat, guard;
    logic [19:0] v;
    rst_n = 1'b0; ena = 1'b1; send_req = 1'b0; scan_mode = 1'b0;
    ch_sel = 2'd0; cnt_bus = '0; use3 = 1'b0;
    for (int i = 0; i < 4; i++) cnt_m[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_out", 64'({tx_data, tx_valid, busy, frame_done, scan_done}), 64'd0);
    check("reset_out3", 64'({tx_data3, tx_valid3, busy3, frame_done3, scan_done3}), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++) set_cnt(i, 20'($urandom));
    set_cnt(1, 20'hABCDE);
    run_single(1, 20'hABCDE, "single", 0);
    set_cnt(1, 20'hABCDF);
    run_single(1, 20'hABCDF, "parity1", 0);

    set_cnt(0, 20'h00001); set_cnt(1, 20'h80000);
    set_cnt(2, 20'hFFFFF); set_cnt(3, 20'h12345);
    run_scan();

    for (int r = 0; r < 6; r++) begin
      int ch;
      for (int i = 0; i < 4; i++) set_cnt(i, 20'($urandom));
      ch = $urandom_range(0, 3);
      run_single(ch, cnt_m[ch], "rand", 0);
    end

    base = vrise_cnt;
    v = 20'($urandom);
    set_cnt(2, v);
    run_single(2, v, "snap", 2);
    repeat (60) @(negedge clk);
    check("snap_no_retrig", 64'(vrise_cnt - base), 64'd1);

    v = 20'($urandom);
    set_cnt(3, v);
    run_single(3, v, "ena", 1);

    use3 = 1'b1;
    run_single(3, 20'h00000, "oor", 0);
    use3 = 1'b0;
    repeat (60) @(negedge clk);

    base = vrise_cnt;
    send_req = 1'b1;
    repeat (200) @(negedge clk);
    send_req = 1'b0;
    repeat (80) @(negedge clk);
    check("hold_once", 64'(vrise_cnt - base), 64'd1);

    ch_sel = 2'd1;
    set_cnt(1, 20'hABCDE);
    start_req(lat);
    repeat (9) @(negedge clk);
    guard = 0;
    while (!tx_data && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    check("rst_pre", 64'({tx_valid, tx_data}), 64'd3);
    #2 rst_n = 1'b0;
    #1 check("rst_async", 64'({tx_data, tx_valid, busy}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base = vrise_cnt;
    repeat (80) @(negedge clk);
    check("rst_no_resume", 64'(vrise_cnt - base), 64'd0);
    check("rst_idle", 64'({tx_data, tx_valid, busy}), 64'd0);

    v = 20'($urandom);
    set_cnt(0, v);
    run_single(0, v, "post_rst", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
